// File: rtl/ms_link_pkg.sv
// Shared widths and types for the master/slave write link.
package ms_pkg;

  localparam int DW = 8;
  localparam int AW = 2;

  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] data_t;

endpackage

// File: rtl/ms_link_if.sv
// Write channel between the master sequencer and the slave register file.
interface ms_if
  import ms_pkg::*;
#(
  parameter int AW = ms_pkg::AW,
  parameter int DW = ms_pkg::DW
) (
  input logic clk
);

  logic          rst;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          valid;
  logic          sready;

  modport master (output addr, data, valid, input clk, rst, sready);
  modport slave  (input addr, data, valid, clk, rst, output sready);

endinterface

// File: rtl/ms_link_master.sv
// Write sequencer: after reset it keeps valid high and steps address/data on every accept.
module master
  import ms_pkg::*;
#(
  parameter int AW = ms_pkg::AW,
  parameter int DW = ms_pkg::DW
) (
  ms_if.master bus
);

  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [DW-1:0] DATA_ONE = DW'(1);

  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q;
  logic          accept_s;

  assign accept_s = valid_q && bus.sready;

  // Advance the sequence only when the slave takes the current beat.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    if (accept_s) begin
      addr_d = addr_q + ADDR_ONE;
      data_d = data_q + DATA_ONE;
    end else begin
      addr_d = addr_q;
      data_d = data_q;
    end
  end

  // Sequencer state with synchronous reset.
  always_ff @(posedge bus.clk) begin
    if (bus.rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= 1'b1;
    end
  end

  assign bus.addr  = addr_q;
  assign bus.data  = data_q;
  assign bus.valid = valid_q;

endmodule

// File: rtl/ms_link_slave.sv
// Write sink: register file, post-write busy window and accepted-write counter.
module slave
  import ms_pkg::*;
#(
  parameter int AW   = ms_pkg::AW,
  parameter int DW   = ms_pkg::DW,
  parameter int BUSY = 1
) (
  ms_if.slave           bus,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic [15:0]   wr_count
);

  localparam int         DEPTH     = 2 ** AW;
  localparam logic [3:0] BUSY_INIT = 4'(BUSY);

  logic [DW-1:0] mem_q [DEPTH];
  logic          sready_q, sready_d;
  logic [3:0]    busy_q, busy_d;
  logic [15:0]   wr_count_q, wr_count_d;
  logic          accept_s;

  assign accept_s = bus.valid && sready_q;

  // sready drops for BUSY cycles after each accept and returns as the counter hits zero.
  always_comb begin
    sready_d   = sready_q;
    busy_d     = busy_q;
    wr_count_d = wr_count_q;
    if (accept_s) begin
      wr_count_d = wr_count_q + 16'd1;
      busy_d     = BUSY_INIT;
      sready_d   = (BUSY_INIT == 4'd0);
    end else if (busy_q != 4'd0) begin
      busy_d   = busy_q - 4'd1;
      sready_d = (busy_q == 4'd1);
    end else begin
      sready_d = 1'b1;
    end
  end

  // Control registers and register file, all cleared by reset.
  always_ff @(posedge bus.clk) begin
    if (bus.rst) begin
      sready_q   <= 1'b0;
      busy_q     <= 4'd0;
      wr_count_q <= 16'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      sready_q   <= sready_d;
      busy_q     <= busy_d;
      wr_count_q <= wr_count_d;
      if (accept_s) begin
        mem_q[bus.addr] <= bus.data;
      end
    end
  end

  assign bus.sready = sready_q;
  assign rd_data    = mem_q[rd_addr];
  assign wr_count   = wr_count_q;

endmodule

// File: rtl/ms_link.sv
// Top wrapper: one write channel joining the master sequencer to the slave register file.
module ms_link
  import ms_pkg::*;
#(
  parameter int DW   = ms_pkg::DW,
  parameter int AW   = ms_pkg::AW,
  parameter int BUSY = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic [15:0]   wr_count
);

  ms_if #(.AW(AW), .DW(DW)) bus (.clk(clk));

  assign bus.rst = rst;

  master #(.AW(AW), .DW(DW)) u_master (
    .bus (bus)
  );

  slave #(.AW(AW), .DW(DW), .BUSY(BUSY)) u_slave (
    .bus      (bus),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_count (wr_count)
  );

endmodule

// File: tb/tb_ms_link.sv
// Scoreboard bench for ms_link: one instance with BUSY=1 and one with BUSY=0 run in lockstep.
module tb_ms_link;
  import ms_pkg::*;

  typedef struct packed {
    logic [1:0]  a;
    logic [7:0]  d;
    logic [15:0] c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  rd_addr1 = 2'd0;
  logic [1:0]  rd_addr0 = 2'd0;
  logic [7:0]  rd_data1, rd_data0;
  logic [15:0] wr_count1, wr_count0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t sb0[$];
  exp_t sb1[$];

  // Reference model, index 0 = BUSY 0 instance, index 1 = BUSY 1 instance.
  logic        m_valid  [2];
  logic        m_sready [2];
  int          m_busy   [2];
  logic [1:0]  m_addr   [2];
  logic [7:0]  m_data   [2];
  logic [15:0] m_count  [2];
  logic [7:0]  m_mem    [2][4];
  int          busy_cfg [2] = '{0, 1};

  logic [7:0] steady_exp [4] = '{8'h08, 8'h09, 8'h06, 8'h07};

  always #5 clk = ~clk;

  ms_link #(.BUSY(1)) u_b1 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr1), .rd_data(rd_data1), .wr_count(wr_count1)
  );

  ms_link #(.BUSY(0)) u_b0 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr0), .rd_data(rd_data0), .wr_count(wr_count0)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input int k, output logic acc);
    exp_t e;
    acc = 1'b0;
    if (rst) begin
      m_valid[k]  = 1'b0;
      m_sready[k] = 1'b0;
      m_busy[k]   = 0;
      m_addr[k]   = 2'd0;
      m_data[k]   = 8'd0;
      m_count[k]  = 16'd0;
      for (int a = 0; a < 4; a++) m_mem[k][a] = 8'd0;
    end else begin
      acc = m_valid[k] && m_sready[k];
      if (acc) begin
        m_mem[k][m_addr[k]] = m_data[k];
        m_count[k] = m_count[k] + 16'd1;
        e.a = m_addr[k];
        e.d = m_data[k];
        e.c = m_count[k];
        if (k == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        m_addr[k]   = m_addr[k] + 2'd1;
        m_data[k]   = m_data[k] + 8'd1;
        m_sready[k] = (busy_cfg[k] == 0);
        m_busy[k]   = busy_cfg[k];
      end else if (m_busy[k] != 0) begin
        m_busy[k]   = m_busy[k] - 1;
        m_sready[k] = (m_busy[k] == 0);
      end else begin
        m_sready[k] = 1'b1;
      end
      m_valid[k] = 1'b1;
    end
  endtask

  // One clock edge: sample the bus before it, advance the model, score after it.
  task automatic step();
    logic       dacc [2];
    logic [1:0] da   [2];
    logic [7:0] dd   [2];
    logic       macc [2];
    exp_t       e;
    dacc[0] = u_b0.bus.valid && u_b0.bus.sready;
    da[0]   = u_b0.bus.addr;
    dd[0]   = u_b0.bus.data;
    dacc[1] = u_b1.bus.valid && u_b1.bus.sready;
    da[1]   = u_b1.bus.addr;
    dd[1]   = u_b1.bus.data;
    @(posedge clk);
    model_edge(0, macc[0]);
    model_edge(1, macc[1]);
    #1;
    cyc++;
    check_eq("wr_count_b0", wr_count0, m_count[0]);
    check_eq("wr_count_b1", wr_count1, m_count[1]);
    if (!rst) begin
      check_eq("accept_b0", dacc[0], macc[0]);
      check_eq("accept_b1", dacc[1], macc[1]);
      if (dacc[0] && macc[0]) begin
        e = sb0.pop_front();
        check_eq("sb_addr_b0", da[0], e.a);
        check_eq("sb_data_b0", dd[0], e.d);
        check_eq("sb_count_b0", wr_count0, e.c);
      end
      if (dacc[1] && macc[1]) begin
        e = sb1.pop_front();
        check_eq("sb_addr_b1", da[1], e.a);
        check_eq("sb_data_b1", dd[1], e.d);
        check_eq("sb_count_b1", wr_count1, e.c);
      end
    end
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 4; a++) begin
      rd_addr0 = 2'(a);
      rd_addr1 = 2'(a);
      #1;
      check_eq({tag, "_b0"}, rd_data0, m_mem[0][a]);
      check_eq({tag, "_b1"}, rd_data1, m_mem[1][a]);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (5) step();
    check_eq("rst_valid", u_b1.bus.valid, 1'b0);
    check_eq("rst_sready", u_b1.bus.sready, 1'b0);
    check_eq("rst_sready_b0", u_b0.bus.sready, 1'b0);
    check_eq("rst_wr_count", wr_count1, 16'd0);
    for (int a = 0; a < 4; a++) begin
      rd_addr1 = 2'(a);
      #1;
      check_eq("rst_mem", rd_data1, 8'h00);
    end
    sweep("rst_sweep");

    rst = 1'b0;
    step();
    check_eq("e0_valid", u_b1.bus.valid, 1'b1);
    check_eq("e0_sready", u_b1.bus.sready, 1'b1);
    step();
    rd_addr1 = 2'd0;
    #1;
    check_eq("e1_mem0", rd_data1, 8'h00);
    check_eq("e1_wr_count", wr_count1, 16'd1);
    check_eq("e1_sready", u_b1.bus.sready, 1'b0);
    check_eq("e1_addr", u_b1.bus.addr, 2'd1);
    check_eq("e1_data", u_b1.bus.data, 8'h01);
    step();
    check_eq("e2_sready", u_b1.bus.sready, 1'b1);

    for (int i = 3; i < 20; i++) begin
      step();
      if (i == 4) begin
        rd_addr0 = 2'd0;
        #1;
        check_eq("same_edge_old", rd_data0, 8'h00);
      end
      if (i == 5) begin
        #1;
        check_eq("same_edge_new", rd_data0, 8'h04);
      end
      if (i == 8) begin
        check_eq("b2b_wr_count", wr_count0, 16'd8);
        rd_addr0 = 2'd3;
        #1;
        check_eq("b2b_mem3", rd_data0, 8'h07);
      end
      if (i == 9) begin
        rd_addr1 = 2'd0;
        #1;
        check_eq("wrap_mem0", rd_data1, 8'h04);
        check_eq("wrap_addr", u_b1.bus.addr, 2'd1);
      end
    end
    check_eq("steady_wr_count", wr_count1, 16'd10);
    for (int a = 0; a < 4; a++) begin
      rd_addr1 = 2'(a);
      #1;
      check_eq("steady_mem", rd_data1, steady_exp[a]);
    end
    sweep("steady_sweep");

    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_rst_count_b1", wr_count1, 16'd0);
    check_eq("mid_rst_count_b0", wr_count0, 16'd0);
    check_eq("mid_rst_valid", u_b1.bus.valid, 1'b0);
    check_eq("mid_rst_addr", u_b0.bus.addr, 2'd0);
    sweep("mid_rst_mem");
    step();
    step();
    rd_addr1 = 2'd0;
    #1;
    check_eq("restart_mem0", rd_data1, 8'h00);
    check_eq("restart_count", wr_count1, 16'd1);

    repeat (12) step();
    sweep("final_sweep");
    check_eq("sb0_drained", sb0.size(), 0);
    check_eq("sb1_drained", sb1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
